// File: rtl/sigmul_iter.sv
// Iterative significand multiplier: retires RADIX_BITS bits of b per cycle into a
// carry-save accumulator, then resolves the product with one carry-propagate add.
module sigmul_iter #(
  parameter int unsigned NSIG       = 52,
  parameter int unsigned RADIX_BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NSIG:0]     a,
  input  logic [NSIG:0]     b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*NSIG+1:0] p
);

  localparam int unsigned W    = NSIG + 1;
  localparam int unsigned PW   = 2 * NSIG + 2;
  localparam int unsigned ITER = (W + RADIX_BITS - 1) / RADIX_BITS;
  localparam int unsigned BW   = ITER * RADIX_BITS;
  localparam int unsigned CW   = $clog2(ITER + 1);

  if (RADIX_BITS < 1 || RADIX_BITS > 8) begin : g_bad_radix
    $error("sigmul_iter: RADIX_BITS must be in 1..8");
  end

  typedef enum logic [1:0] {StIdle, StMul, StAdd, StDone} state_e;

  state_e          r_state, w_state_nx;
  logic [PW-1:0]   r_a, r_sum, r_carry, r_p;
  logic [BW-1:0]   r_b;
  logic [CW-1:0]   r_cnt;
  logic            w_accept, w_last;
  logic [PW-1:0]   w_csa_sum, w_csa_carry;

  assign in_ready  = (r_state == StIdle) || ((r_state == StDone) && out_ready);
  assign out_valid = (r_state == StDone);
  assign p         = r_p;
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_cnt == CW'(ITER - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_nx;
  end

  always_comb begin : next_state
    w_state_nx = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_nx = StMul;
      StMul:   if (w_last) w_state_nx = StAdd;
      StAdd:   w_state_nx = StDone;
      StDone:  if (out_ready) w_state_nx = in_valid ? StMul : StIdle;
      default: w_state_nx = StIdle;
    endcase
  end

  // r_a is pre-shifted by the digit position, so partial product j is just r_a << j.
  always_comb begin : csa_chain
    logic [PW-1:0] v_pp, v_s;
    w_csa_sum   = r_sum;
    w_csa_carry = r_carry;
    for (int j = 0; j < RADIX_BITS; j++) begin
      v_pp        = r_b[j] ? (r_a << j) : '0;
      v_s         = w_csa_sum ^ w_csa_carry ^ v_pp;
      w_csa_carry = ((w_csa_sum & w_csa_carry) | (w_csa_sum & v_pp) |
                     (w_csa_carry & v_pp)) << 1;
      w_csa_sum   = v_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= '0;
      r_cnt   <= '0;
      r_p     <= '0;
    end else begin
      if (w_accept) begin
        r_a     <= PW'(a);
        r_b     <= BW'(b);
        r_sum   <= '0;
        r_carry <= '0;
        r_cnt   <= '0;
      end else if (r_state == StMul) begin
        r_a     <= r_a << RADIX_BITS;
        r_b     <= r_b >> RADIX_BITS;
        r_sum   <= w_csa_sum;
        r_carry <= w_csa_carry;
        r_cnt   <= r_cnt + 1'b1;
      end
      // Carries lost off the MSB are harmless: the true product fits in PW bits.
      if (r_state == StAdd) r_p <= r_sum + r_carry;
    end
  end

endmodule

// File: tb/tb_sigmul_iter.sv
// Self-checking bench for sigmul_iter: directed table, backpressure, async reset,
// and random operands on two parameterisations against a plain a*b model.
module tb_sigmul_iter;

  localparam int unsigned N0 = 52, R0 = 4, LAT0 = 15;
  localparam int unsigned N1 = 10, R1 = 3, LAT1 = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic iv0 = 0, or0 = 0, ir0, ov0;
  logic [N0:0] a0 = '0, b0 = '0;
  logic [2*N0+1:0] p0;
  logic iv1 = 0, or1 = 0, ir1, ov1;
  logic [N1:0] a1 = '0, b1 = '0;
  logic [2*N1+1:0] p1;

  sigmul_iter #(.NSIG(N0), .RADIX_BITS(R0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
    .out_valid(ov0), .out_ready(or0), .p(p0));

  sigmul_iter #(.NSIG(N1), .RADIX_BITS(R1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .out_valid(ov1), .out_ready(or1), .p(p1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [52:0]  a;
    logic [52:0]  b;
    logic [105:0] p;
  } vec_t;
  vec_t vecs[8];

  // Present operands (at posedge+1) and return just after the accepting edge.
  task automatic start0(input logic [52:0] ta, input logic [52:0] tb_);
    int n = 0;
    a0 = ta; b0 = tb_; iv0 = 1'b1;
    while (!ir0 && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("accept0_timeout", 0, 1);
    @(posedge clk); #1;
    iv0 = 1'b0;
    a0 = 53'({$urandom(), $urandom()});
    b0 = 53'({$urandom(), $urandom()});
  endtask

  task automatic wait0(output int lat, output bit busy_bad);
    lat = 0; busy_bad = 0;
    while (!ov0 && lat < 100) begin
      if (ir0) busy_bad = 1;
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic op0(input string name, input logic [52:0] ta, input logic [52:0] tb_,
                     input logic [105:0] exp, input int hold);
    int lat; bit bb;
    start0(ta, tb_);
    wait0(lat, bb);
    chk({name, "_lat"}, lat, LAT0);
    chk({name, "_busy"}, bb, 0);
    chk({name, "_p"}, p0, exp);
    repeat (hold) begin @(posedge clk); #1; end
    or0 = 1'b1; @(posedge clk); #1; or0 = 1'b0;
    chk({name, "_drop"}, ov0, 0);
  endtask

  task automatic op1(input logic [10:0] ta, input logic [10:0] tb_, input int hold);
    int n = 0, lat = 0;
    logic [21:0] exp = 22'(ta) * 22'(tb_);
    a1 = ta; b1 = tb_; iv1 = 1'b1;
    while (!ir1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    iv1 = 1'b0; a1 = 11'($urandom()); b1 = 11'($urandom());
    while (!ov1 && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("rand1_lat", lat, LAT1);
    chk("rand1_p", p1, exp);
    repeat (hold) begin @(posedge clk); #1; end
    or1 = 1'b1; @(posedge clk); #1; or1 = 1'b0;
  endtask

  initial begin
    logic [52:0] ones, ra, rb;
    logic [105:0] pexp;
    int lat; bit bb, bad;
    ones = '1;
    vecs[0] = '{53'(1) << 52, 53'(1) << 52, 106'(1) << 104};
    vecs[1] = '{ones, ones, {106{1'b1}} - (106'(1) << 54) + 106'(2)};
    vecs[2] = '{ones, 53'd0, 106'd0};
    vecs[3] = '{53'd0, 53'(1) << 52, 106'd0};
    vecs[4] = '{53'd1, 53'd1, 106'd1};
    vecs[5] = '{ones, 53'd1, 106'(ones)};
    vecs[6] = '{53'd3, 53'd5, 106'd15};
    vecs[7] = '{53'(1) << 52, ones, 106'(ones) << 52};

    #12;
    chk("rst_in_ready", ir0, 1);
    chk("rst_out_valid", ov0, 0);
    chk("rst_p", p0, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) op0($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p, i % 3);

    // Backpressure, then retire and accept in the same cycle.
    ra = 53'h1F_0123_4567_89AB; rb = 53'h10_FEDC_BA98_7654;
    pexp = 106'(ra) * 106'(rb);
    start0(ra, rb);
    wait0(lat, bb);
    chk("bp_lat", lat, LAT0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ov0 !== 1'b1 || p0 !== pexp || ir0 !== 1'b0) bad = 1;
    end
    chk("bp_stable", bad, 0);
    ra = 53'h1A_AAAA_5555_AAAA; rb = 53'h15_5555_AAAA_5555;
    a0 = ra; b0 = rb; iv0 = 1'b1; or0 = 1'b1;
    #1;
    chk("bp_in_ready_follows", ir0, 1);
    @(posedge clk); #1;
    iv0 = 1'b0; or0 = 1'b0; a0 = '0; b0 = '0;
    chk("b2b_out_valid_drop", ov0, 0);
    wait0(lat, bb);
    chk("b2b_lat", lat, LAT0);
    chk("b2b_busy", bb, 0);
    pexp = 106'(ra) * 106'(rb);
    chk("b2b_p", p0, pexp);
    or0 = 1'b1; @(posedge clk); #1; or0 = 1'b0;
    chk("idle_p_hold", p0, pexp);

    // Asynchronous reset mid-MUL aborts the operation.
    start0(ones, ones);
    repeat (6) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", ov0, 0);
    chk("arst_p", p0, 0);
    chk("arst_in_ready", ir0, 1);
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    op0("post_rst", 53'h1C_0000_0000_0001, 53'h13_3333_3333_3333,
        106'(53'h1C_0000_0000_0001) * 106'(53'h13_3333_3333_3333), 0);

    for (int i = 0; i < 150; i++) begin
      ra = 53'({$urandom(), $urandom()});
      rb = 53'({$urandom(), $urandom()});
      if (i % 2 == 0) begin ra[52] = 1'b1; rb[52] = 1'b1; end
      if (i % 17 == 5) ra = '0;
      op0("rand0", ra, rb, 106'(ra) * 106'(rb), int'($urandom_range(0, 2)));
    end
    for (int i = 0; i < 300; i++) begin
      logic [10:0] x, y;
      x = 11'($urandom()); y = 11'($urandom());
      if (i % 2 == 0) begin x[10] = 1'b1; y[10] = 1'b1; end
      if (i % 13 == 3) y = '1;
      op1(x, y, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
